// File: rtl/camera_pkg.sv
// Shared constants for the camera capture path: frame defaults, pixel-word
// field positions and the SDRAM writer state encoding.
package camera_pkg;

    localparam int DEF_WIDTH  = 640;
    localparam int DEF_HEIGHT = 480;

    localparam int X_MSB   = 35;
    localparam int X_LSB   = 26;
    localparam int Y_MSB   = 25;
    localparam int Y_LSB   = 16;
    localparam int RGB_MSB = 15;
    localparam int RGB_LSB = 0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALL = 1'b1
    } state_e;

endpackage

// File: rtl/camera_fifo.sv
// Synchronous first-word-fall-through FIFO; a write into a full FIFO is
// accepted only when a read happens in the same cycle.
module camera_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                         CLOCK,
    input  logic                         RESET,
    input  logic                         iWrite,
    input  logic [W-1:0]                 iData,
    input  logic                         iRead,
    output logic [W-1:0]                 oData,
    output logic                         oEmpty,
    output logic                         oFull,
    output logic [$clog2(DEPTH+1)-1:0]   oCount
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_en_s;
    logic          rd_en_s;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rd_en_s  = iRead && (count_q != {CW{1'b0}});
        wr_en_s  = iWrite && ((count_q != CW'(DEPTH)) || rd_en_s);
        if (wr_en_s) begin
            mem_d[wr_ptr_q] = iData;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers with synchronous active-low reset.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge CLOCK) begin
        mem_q <= mem_d;
    end

    assign oData  = mem_q[rd_ptr_q];
    assign oEmpty = (count_q == {CW{1'b0}});
    assign oFull  = (count_q == CW'(DEPTH));
    assign oCount = count_q;

endmodule

// File: rtl/camera_savemod.sv
// Crops capture pixel words to the frame, computes the linear frame-buffer
// address, queues them and writes each to SDRAM with a Call/Done handshake.
module camera_savemod
    import camera_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int DEPTH  = 16,
    parameter int AW     = 19
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          iEn,
    input  logic [35:0]   iData,
    output logic          oCall,
    input  logic          iDone,
    output logic [AW-1:0] oAddr,
    output logic [15:0]   oData,
    output logic          oFrameDone,
    output logic          oOverflow
);

    localparam int FW = 1 + AW + 16;
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [10:0] WIDTH_L  = 11'(WIDTH);
    localparam logic [10:0] HEIGHT_L = 11'(HEIGHT);

    logic [9:0]    px_s, py_s;
    logic          in_win_s;
    logic          s1_valid_q, s1_valid_d;
    logic          s1_last_q, s1_last_d;
    logic [9:0]    s1_x_q, s1_x_d;
    logic [9:0]    s1_y_q, s1_y_d;
    logic [15:0]   s1_rgb_q, s1_rgb_d;

    logic [AW-1:0] addr_s;
    logic [FW-1:0] push_data_s;
    logic [FW-1:0] fifo_rdata_s;
    logic          fifo_write_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic [CW-1:0] fifo_count_s;
    logic          pop_s;
    logic          drop_s;

    state_e        state_q, state_d;
    logic          call_q, call_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   data_q, data_d;
    logic          last_q, last_d;
    logic          frame_done_q, frame_done_d;
    logic          overflow_q, overflow_d;

    // Window filter; out-of-frame words never enter the pipeline.
    always_comb begin
        px_s       = iData[X_MSB:X_LSB];
        py_s       = iData[Y_MSB:Y_LSB];
        in_win_s   = iEn && ({1'b0, px_s} < WIDTH_L) && ({1'b0, py_s} < HEIGHT_L);
        s1_valid_d = in_win_s;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_rgb_d   = s1_rgb_q;
        s1_last_d  = s1_last_q;
        if (in_win_s) begin
            s1_x_d    = px_s;
            s1_y_d    = py_s;
            s1_rgb_d  = iData[RGB_MSB:RGB_LSB];
            s1_last_d = ({1'b0, px_s} == (WIDTH_L - 11'd1)) &&
                        ({1'b0, py_s} == (HEIGHT_L - 11'd1));
        end else begin
            s1_last_d = s1_last_q;
        end
    end

    // Address is a constant multiply; the parameter rule guarantees it fits AW.
    always_comb begin
        addr_s       = AW'(s1_y_q) * AW'(WIDTH) + AW'(s1_x_q);
        push_data_s  = {s1_last_q, addr_s, s1_rgb_q};
        fifo_write_s = s1_valid_q && (!fifo_full_s || pop_s);
        drop_s       = s1_valid_q && (fifo_count_s == CW'(DEPTH)) && !pop_s;
        overflow_d   = overflow_q || drop_s;
    end

    camera_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .iWrite (fifo_write_s),
        .iData  (push_data_s),
        .iRead  (pop_s),
        .oData  (fifo_rdata_s),
        .oEmpty (fifo_empty_s),
        .oFull  (fifo_full_s),
        .oCount (fifo_count_s)
    );

    // Writer FSM: pop into the output registers, hold until acknowledged.
    always_comb begin
        state_d      = state_q;
        call_d       = call_q;
        addr_d       = addr_q;
        data_d       = data_q;
        last_d       = last_q;
        frame_done_d = 1'b0;
        pop_s        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    addr_d  = fifo_rdata_s[FW-2:RGB_MSB+1];
                    data_d  = fifo_rdata_s[RGB_MSB:RGB_LSB];
                    last_d  = fifo_rdata_s[FW-1];
                    call_d  = 1'b1;
                    state_d = CALL;
                end else begin
                    call_d = 1'b0;
                end
            end
            CALL: begin
                if (iDone) begin
                    call_d       = 1'b0;
                    frame_done_d = last_q;
                    state_d      = IDLE;
                end else begin
                    call_d = 1'b1;
                end
            end
            default: begin
                call_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Pipeline, FSM and flag registers with synchronous active-low reset.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_x_q       <= 10'd0;
            s1_y_q       <= 10'd0;
            s1_rgb_q     <= 16'd0;
            state_q      <= IDLE;
            call_q       <= 1'b0;
            addr_q       <= {AW{1'b0}};
            data_q       <= 16'd0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_last_q    <= s1_last_d;
            s1_x_q       <= s1_x_d;
            s1_y_q       <= s1_y_d;
            s1_rgb_q     <= s1_rgb_d;
            state_q      <= state_d;
            call_q       <= call_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            last_q       <= last_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign oCall      = call_q;
    assign oAddr      = addr_q;
    assign oData      = data_q;
    assign oFrameDone = frame_done_q;
    assign oOverflow  = overflow_q;

endmodule

// File: tb/tb_camera_savemod.sv
// Scoreboard bench for camera_savemod: expected writes are queued at stimulus
// time and compared when the DUT raises oCall; a responder returns iDone.
module tb_camera_savemod;

    localparam int WIDTH  = 640;
    localparam int HEIGHT = 480;
    localparam int DEPTH  = 16;
    localparam int AW     = 19;

    typedef struct packed {
        logic          last;
        logic [AW-1:0] addr;
        logic [15:0]   rgb;
    } exp_t;

    logic          CLOCK = 1'b0;
    logic          RESET;
    logic          iEn;
    logic [35:0]   iData;
    logic          oCall;
    logic          iDone;
    logic [AW-1:0] oAddr;
    logic [15:0]   oData;
    logic          oFrameDone;
    logic          oOverflow;

    exp_t exp_q[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   n_written = 0;
    int   fd_count  = 0;
    logic resp_en   = 1'b0;
    int   resp_lat  = 1;
    logic ack_now   = 1'b0;
    logic in_call   = 1'b0;
    logic ack_pending = 1'b0;
    logic cur_last  = 1'b0;
    int   call_age  = 0;

    always #5 CLOCK = ~CLOCK;

    camera_savemod #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .iEn        (iEn),
        .iData      (iData),
        .oCall      (oCall),
        .iDone      (iDone),
        .oAddr      (oAddr),
        .oData      (oData),
        .oFrameDone (oFrameDone),
        .oOverflow  (oOverflow)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Monitor and SDRAM responder, evaluated on the falling edge.
    initial begin
        exp_t e;
        iDone = 1'b0;
        forever begin
            @(negedge CLOCK);
            if (ack_pending) begin
                ack_pending = 1'b0;
                iDone       = 1'b0;
                in_call     = 1'b0;
                check_eq("call_fall", 64'(oCall), 64'd0);
                check_eq("frame_done", 64'(oFrameDone), 64'(cur_last));
                if (oFrameDone) fd_count++;
            end else begin
                check_eq("no_stray_frame_done", 64'(oFrameDone), 64'd0);
                if (in_call && !oCall) in_call = 1'b0;
                if (oCall && !in_call) begin
                    in_call  = 1'b1;
                    call_age = 0;
                    n_written++;
                    check_eq("call_has_expect", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_eq("addr", 64'(oAddr), 64'(e.addr));
                        check_eq("data", 64'(oData), 64'(e.rgb));
                        cur_last = e.last;
                    end
                end
                if (in_call && ((resp_en && call_age >= resp_lat) || ack_now)) begin
                    iDone       = 1'b1;
                    ack_pending = 1'b1;
                end else if (in_call && resp_en) begin
                    call_age++;
                end
            end
        end
    end

    task automatic drive_word(input int x, input int y, input logic [15:0] rgb, input bit expect_it);
        exp_t e;
        iEn   = 1'b1;
        iData = {10'(x), 10'(y), rgb};
        if (expect_it && x < WIDTH && y < HEIGHT) begin
            e.last = (x == WIDTH-1) && (y == HEIGHT-1);
            e.addr = AW'(y * WIDTH + x);
            e.rgb  = rgb;
            exp_q.push_back(e);
        end
        @(negedge CLOCK);
        iEn = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while ((exp_q.size() != 0 || in_call || oCall) && k < 600) begin
            @(negedge CLOCK);
            k++;
        end
        check_eq(tag, 64'(k < 600), 64'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_call"},  64'(oCall),      64'd0);
        check_eq({tag, "_addr"},  64'(oAddr),      64'd0);
        check_eq({tag, "_data"},  64'(oData),      64'd0);
        check_eq({tag, "_fd"},    64'(oFrameDone), 64'd0);
        check_eq({tag, "_ovf"},   64'(oOverflow),  64'd0);
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge CLOCK);
        check_outputs_zero("reset");
        RESET = 1'b1;
        @(negedge CLOCK);
    endtask

    initial begin
        int w0;
        int fd0;
        int lat;
        RESET = 1'b0;
        iEn   = 1'b0;
        iData = 36'd0;
        repeat (3) @(negedge CLOCK);
        check_outputs_zero("init");
        check_eq("init_empty", 64'(dut.u_fifo.oEmpty), 64'd1);
        RESET    = 1'b1;
        resp_en  = 1'b1;
        resp_lat = 1;
        @(negedge CLOCK);

        // Single word: latency, address and data.
        fd0 = fd_count;
        drive_word(5, 2, 16'hF800, 1'b1);
        lat = 1;
        while (!oCall && lat < 20) begin
            @(negedge CLOCK);
            lat++;
        end
        check_eq("latency", 64'(lat), 64'd3);
        check_eq("t1_addr", 64'(oAddr), 64'd1285);
        check_eq("t1_data", 64'(oData), 64'hF800);
        wait_drain("t1_drain");
        check_eq("t1_no_fd", 64'(fd_count - fd0), 64'd0);

        // Cropping.
        w0 = n_written;
        drive_word(640, 0, 16'h1234, 1'b1);
        drive_word(0, 480, 16'h4321, 1'b1);
        repeat (6) @(negedge CLOCK);
        check_eq("crop_no_write", 64'(n_written - w0), 64'd0);
        check_eq("crop_empty", 64'(dut.u_fifo.oEmpty), 64'd1);
        check_eq("crop_ovf", 64'(oOverflow), 64'd0);

        // Last pixel of the frame.
        fd0 = fd_count;
        drive_word(639, 479, 16'h07E0, 1'b1);
        lat = 1;
        while (!oCall && lat < 20) begin
            @(negedge CLOCK);
            lat++;
        end
        check_eq("last_addr", 64'(oAddr), 64'd307199);
        wait_drain("last_drain");
        check_eq("last_fd_pulses", 64'(fd_count - fd0), 64'd1);

        // Mixed words, some out of window, slower responder.
        resp_lat = 3;
        for (int i = 0; i < 10; i++) begin
            drive_word(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                       16'($urandom), 1'b1);
            @(negedge CLOCK);
        end
        wait_drain("mixed_drain");

        // Full FIFO with a push coinciding with a pop.
        do_reset();
        resp_en = 1'b0;
        w0 = n_written;
        for (int i = 0; i < 17; i++) drive_word(i, 10, 16'(16'h0100 + i), 1'b1);
        repeat (4) @(negedge CLOCK);
        check_eq("full_count", 64'(dut.u_fifo.oCount), 64'd16);
        check_eq("full_call", 64'(oCall), 64'd1);
        @(posedge CLOCK);
        #1 ack_now = 1'b1;
        @(negedge CLOCK);
        drive_word(100, 10, 16'hBEEF, 1'b1);
        @(posedge CLOCK);
        #1 ack_now = 1'b0;
        @(negedge CLOCK);
        check_eq("fwp_count", 64'(dut.u_fifo.oCount), 64'd16);
        check_eq("fwp_ovf", 64'(oOverflow), 64'd0);
        check_eq("fwp_call", 64'(oCall), 64'd1);
        resp_en  = 1'b1;
        resp_lat = 1;
        wait_drain("fwp_drain");
        check_eq("fwp_written", 64'(n_written - w0), 64'd18);

        // Overflow: 20 back-to-back words with iDone withheld.
        do_reset();
        resp_en = 1'b0;
        w0 = n_written;
        for (int i = 0; i < 20; i++) drive_word(i, 20, 16'(16'h0A00 + i), i < 17);
        repeat (4) @(negedge CLOCK);
        check_eq("ovf_set", 64'(oOverflow), 64'd1);
        resp_en = 1'b1;
        wait_drain("ovf_drain");
        repeat (4) @(negedge CLOCK);
        check_eq("ovf_written", 64'(n_written - w0), 64'd17);
        check_eq("ovf_sticky", 64'(oOverflow), 64'd1);

        // Reset in the middle of a transaction.
        do_reset();
        resp_en = 1'b0;
        for (int i = 0; i < 6; i++) drive_word(i, 30, 16'(16'h0C00 + i), 1'b1);
        repeat (4) @(negedge CLOCK);
        check_eq("mid_call", 64'(oCall), 64'd1);
        check_eq("mid_count", 64'(dut.u_fifo.oCount), 64'd5);
        RESET = 1'b0;
        exp_q.delete();
        @(negedge CLOCK);
        check_outputs_zero("mid_reset");
        RESET = 1'b1;
        resp_en = 1'b1;
        w0 = n_written;
        repeat (10) @(negedge CLOCK);
        check_eq("mid_no_call", 64'(n_written - w0), 64'd0);
        check_eq("mid_call_low", 64'(oCall), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, failed=%0d", n_fail);
        $fatal(1);
    end

endmodule

// File: doc/camera_savemod.md
# camera_savemod

Downstream stage of the camera capture function module. Accepts the 36-bit pixel words (`{X[9:0], Y[9:0], RGB565[15:0]}`) it emits, crops them to the frame window and computes the linear frame-buffer address. It buffers the words in a small synchronous FIFO and writes them one at a time to the SDRAM write port using the team's Call/Done handshake. It also reports end-of-frame and a sticky overflow.

## Interface
Parameters:
- `WIDTH`, 640, frame width in pixels; X ≥ WIDTH is discarded
- `HEIGHT`, 480, frame height in lines; Y ≥ HEIGHT is discarded
- `DEPTH`, 16, FIFO depth in entries, power of two, ≥ 4
- `AW`, 19, address width; must satisfy WIDTH*HEIGHT ≤ 2^AW

Ports:
- `CLOCK` in 1 — single clock for the block
- `RESET` in 1 — synchronous, active-low reset
- `iEn` in 1 — pixel word valid, one-cycle pulse, no back-pressure
- `iData` in 36 — [35:26] X, [25:16] Y, [15:0] RGB565
- `oCall` out 1 — write request to SDRAM port
- `iDone` in 1 — one-cycle acknowledge that the current word is written
- `oAddr` out AW — word address = Y*WIDTH + X
- `oData` out 16 — RGB565 word
- `oFrameDone` out 1 — one-cycle pulse when the word at (WIDTH-1, HEIGHT-1) is acknowledged
- `oOverflow` out 1 — sticky; set when a word is dropped because the FIFO is full

## Operation
- Stage 1, filter and register: on `iEn` with X<WIDTH and Y<HEIGHT, the block registers X, Y and RGB with valid=1. Otherwise valid=0.
  - last = (X==WIDTH-1 && Y==HEIGHT-1).
- Stage 2, address: addr = Y*WIDTH + X, zero-extended to AW. No truncation is possible under the parameter rule.
  - The block pushes `{last, addr, rgb}` (1+AW+16 bits) into the FIFO.
- Push rule: the push succeeds if count<DEPTH, or if a pop occurs in the same cycle. Otherwise the word is dropped and `oOverflow` is set to 1. `oOverflow` is cleared only by reset.
- Output FSM, two states:
  - IDLE: `oCall`=0. If the FIFO is not empty, pop the entry into `oAddr`/`oData`/last register, set `oCall`=1, go to CALL.
  - CALL: hold `oCall`=1 and keep `oAddr`/`oData` stable. On `iDone`:
    - set `oCall`=0;
    - pulse `oFrameDone` if last;
    - go to IDLE.
- `iDone` while in IDLE is ignored.
- There is no frame-sync input. Frame boundaries are implied solely by the addresses; a restarted or short frame simply overwrites addresses.

## Timing
- Reset values: `oCall`=0, `oAddr`=0, `oData`=0, `oFrameDone`=0, `oOverflow`=0. FIFO is empty, count=0, FSM is in IDLE, both pipeline valids are 0.
- Latency: `iEn` at edge N → stage-1 valid after N → FIFO entry visible (not empty) after N+1 → pop in IDLE at N+2 → `oCall`=1 after edge N+2 (3 cycles, empty FIFO).
- Per-word turnaround: `iDone` at edge M → `oCall`=0 after M → earliest next `oCall`=1 after M+1. There is always at least one low cycle of `oCall` between words.
- Sustained throughput: 1 word per (SDRAM latency + 2) cycles. The producer averages 1 word per 2 PCLK, so the FIFO absorbs line bursts only.
- Simultaneous push and pop at count==DEPTH: the push is accepted and count stays DEPTH.
- Simultaneous push and pop at count==0 cannot occur, because the pop requires non-empty.
- `oFrameDone` is asserted in the cycle after the `iDone` that acknowledges the last word, together with `oCall` falling.
- Reset asserted mid-transaction: on the next edge all state returns to reset values. `oCall` drops even without `iDone`, and the pending word is abandoned.

## Structure
- Shared package `camera_pkg`:
  - default WIDTH/HEIGHT;
  - `iData` field positions (X_MSB=35, X_LSB=26, Y_MSB=25, Y_LSB=16, RGB_MSB=15);
  - FSM state constants IDLE/CALL.
- Sub-module `camera_fifo`: synchronous FIFO with parameters W and DEPTH.
  - Ports: `CLOCK`, `RESET`, `iWrite`, `iData`, `iRead`, `oData`, `oEmpty`, `oFull`, `oCount`.
  - Read data is combinational from the head entry (first-word fall-through).
- Top level contains the filter, the address multiply (synthesised as constant multiply), the FSM and the flags.

## Test plan
- Single word `iData`={X=5,Y=2,RGB=16'hF800}, `iDone` returned 2 cycles after `oCall` → `oCall` rises 3 cycles after `iEn`; `oAddr`=1285, `oData`=F800; `oFrameDone`=0.
- Cropping: X=640,Y=0 and X=0,Y=480 → no `oCall`, FIFO stays empty, `oOverflow`=0.
- Last pixel X=639,Y=479, RGB=16'h07E0 → `oAddr`=307199 and a one-cycle `oFrameDone` after its `iDone`.
- Overflow: 20 words on consecutive `iEn` with `iDone` withheld → only the first 17 words are written when `iDone` resumes (1 held in output + 16 in FIFO), in input order. `oOverflow`=1 stays set.
- Full-with-pop: fill the FIFO to 16, then `iEn` in the same cycle as the pop → word accepted, count=16, `oOverflow` unchanged.
- Reset while `oCall`=1 with 5 queued words → `oCall`=0 after the next edge. No further `oCall` appears without new input, and all outputs are 0.
